// File: rtl/sr_pulse_driver.sv
// -----------------------------------------------------------------------------
// sr_pulse_driver
//
// Turns single-bit write requests into timed, active-low set/reset pulses for
// a NAND-based SR latch, then reads the latch Q back to report success.
//
// Each accepted request runs IDLE -> PULSE -> RECOVER -> DONE -> IDLE:
//   PULSE   : s_n (target 1) or r_n (target 0) held low for PULSE_CYC cycles
//   RECOVER : both high for RECOVER_CYC cycles so the synchronized Q settles;
//             the Q check is taken on the last recovery cycle
//   DONE    : one-cycle done strobe, err qualified by done
//
// Parameters:
//   PULSE_CYC   - cycles the selected latch input is held low (1..255)
//   RECOVER_CYC - cycles both inputs are high before the Q check (2..255)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   req_valid in   write request present
//   req_val   in   target latch value (1 = set, 0 = reset)
//   req_ready out  request can be accepted this cycle
//   q_fb      in   asynchronous latch Q feedback (synchronized internally)
//   s_n       out  active-low latch set
//   r_n       out  active-low latch reset
//   done      out  one-cycle completion strobe
//   err       out  with done: latch Q did not match the target
//
// Optional feature (compile-time macro SR_SKIP_REDUNDANT_EN):
//   when defined, a request whose target already equals the synchronized Q
//   skips the pulse and completes with done=1, err=0 in the next cycle.
//
// All outputs are registered. s_n and r_n are decoded from a single state
// and a single target bit, so they can never be low together.
// -----------------------------------------------------------------------------
module sr_pulse_driver #(
    parameter int PULSE_CYC   = 4,
    parameter int RECOVER_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    input  logic q_fb,
    output logic s_n,
    output logic r_n,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_RECOVER = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Counters hold "cycles remaining minus one", so loading N-1 yields N cycles.
    localparam logic [7:0] PULSE_LD   = 8'(PULSE_CYC - 1);
    localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYC - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tgt_q, tgt_d;
    logic       sync1_q, q_sync_q;
    logic       s_n_q, s_n_d;
    logic       r_n_q, r_n_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       ready_q, ready_d;

    // Two-flop synchronizer for the asynchronous latch feedback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            q_sync_q <= 1'b0;
        end else begin
            sync1_q  <= q_fb;
            q_sync_q <= sync1_q;
        end
    end

    // Next-state, duration counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ready_q gates the handshake so nothing is accepted in the
                // first cycle after reset release.
                if (req_valid && ready_q) begin
                    tgt_d = req_val;
`ifdef SR_SKIP_REDUNDANT_EN
                    if (q_sync_q == req_val) begin
                        state_d = ST_DONE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_PULSE;
                        cnt_d   = PULSE_LD;
                    end
`else
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RECOVER;
                    cnt_d   = RECOVER_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DONE;
                    cnt_d   = 8'd0;
                    err_d   = (q_sync_q != tgt_q);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with it.
        s_n_d   = !((state_d == ST_PULSE) &&  tgt_d);
        r_n_d   = !((state_d == ST_PULSE) && !tgt_d);
        done_d  = (state_d == ST_DONE);
        ready_d = (state_d == ST_IDLE);
    end

    // State, counter, target and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            tgt_q   <= 1'b0;
            s_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            s_n_q   <= s_n_d;
            r_n_q   <= r_n_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign s_n       = s_n_q;
    assign r_n       = r_n_q;
    assign done      = done_q;
    assign err       = err_q;
    assign req_ready = ready_q;

endmodule
